score_keeper: RTL and testbench

- Consumer end of the ball block's scoring interface.
- Receives the level-style score1/score2 flags from the ball block and converts each new point into exactly one score increment per player.
- Sequences the match through a serve, play, post-point pause and game-over flow.
- Drives a registered ball_hold that the top level routes to the ball block's reset, so the ball is re-centred after every point. Also exports both score counters to the display path.

---
 rtl/score_keeper.sv | 149 ++++++++++++++
 tb/tb_score_keeper.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Point sequencer for the ball block: turns level score flags into single increments
// and walks the match through serve, play, post-point pause and game-over.

module score_keeper_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic flag,
  output logic rise
);
  logic flag_q, flag_d;

  always_comb flag_d = flag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flag_q <= 1'b0;
    else          flag_q <= flag_d;
  end

  assign rise = flag & ~flag_q;
endmodule

module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_FRAMES = 60,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               score1,
  input  logic               score2,
  input  logic               btn_serve,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               ball_hold,
  output logic               game_over,
  output logic [1:0]         winner
);
  localparam int NUM_PLAYERS = 2;
  localparam int CNT_W       = (PAUSE_FRAMES < 1) ? 1 : $clog2(PAUSE_FRAMES + 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   PAUSE_END = CNT_W'(PAUSE_FRAMES);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_e;

  state_e                                    state_q, state_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]       score_q, score_d;
  logic [1:0]                                winner_q, winner_d;
  logic [CNT_W-1:0]                          cnt_q, cnt_d;
  logic                                      hold_q, hold_d;
  logic                                      over_q, over_d;
  logic [2:0]                                serve_sync_q, serve_sync_d;
  logic                                      serve_rise_q, serve_rise_d;
  logic [NUM_PLAYERS-1:0]                    flag_in, rise;
  logic                                      tick;

  assign tick    = (y == 10'd481) && (x == 10'd0);
  assign flag_in = {score2, score1};

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_edge
    score_keeper_edge u_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .flag    (flag_in[p]),
      .rise    (rise[p])
    );
  end

  // Two sync stages, one history stage; the registered pulse gives a 3-cycle latency.
  always_comb begin
    serve_sync_d = {serve_sync_q[1:0], btn_serve};
    serve_rise_d = serve_sync_q[1] & ~serve_sync_q[2];
  end

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (serve_rise_q) state_d = PLAY;
      PLAY: begin
        if (rise == 2'b11) begin
          // Tied point: nobody scores, ball is still re-centred.
          state_d = PAUSE;
          cnt_d   = '0;
        end else begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (rise == NUM_PLAYERS'(1 << p)) begin
              score_d[p] = score_q[p] + 1'b1;
              if (score_d[p] == WIN_VAL) begin
                state_d  = OVER;
                winner_d = 2'(1 << p);
              end else begin
                state_d = PAUSE;
                cnt_d   = '0;
              end
            end
          end
        end
      end
      PAUSE: begin
        if (tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == PAUSE_END) state_d = PLAY;
        end
      end
      OVER: begin
        if (serve_rise_q) begin
          score_d  = '0;
          winner_d = 2'b00;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    hold_d = (state_d != PLAY);
    over_d = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      score_q      <= '0;
      winner_q     <= 2'b00;
      cnt_q        <= '0;
      hold_q       <= 1'b1;
      over_q       <= 1'b0;
      serve_sync_q <= '0;
      serve_rise_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      over_q       <= over_d;
      serve_sync_q <= serve_sync_d;
      serve_rise_q <= serve_rise_d;
    end
  end

  assign p1_score  = score_q[0];
  assign p2_score  = score_q[1];
  assign ball_hold = hold_q;
  assign game_over = over_q;
  assign winner    = winner_q;
endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: expected output snapshots are queued as
// stimulus is applied and compared after the DUT has clocked it in.

module tb_score_keeper;
  logic       clk, reset_n;
  logic [9:0] x, y;
  logic       score1, score2, btn_serve;
  logic [3:0] p1_score, p2_score;
  logic       ball_hold, game_over;
  logic [1:0] winner;

  score_keeper #(.WIN_SCORE(7), .PAUSE_FRAMES(60), .SCORE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y),
    .score1(score1), .score2(score2), .btn_serve(btn_serve),
    .p1_score(p1_score), .p2_score(p2_score),
    .ball_hold(ball_hold), .game_over(game_over), .winner(winner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      tag;
    logic [3:0] p1, p2;
    logic       hold, over;
    logic [1:0] win;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk, n_err;
  logic [3:0] e_p1, e_p2;
  logic       e_hold, e_over;
  logic [1:0] e_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag);
    exp_t e;
    e.tag = tag; e.p1 = e_p1; e.p2 = e_p2;
    e.hold = e_hold; e.over = e_over; e.win = e_win;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    chk({e.tag, ".p1"},   p1_score,  e.p1);
    chk({e.tag, ".p2"},   p2_score,  e.p2);
    chk({e.tag, ".hold"}, ball_hold, e.hold);
    chk({e.tag, ".over"}, game_over, e.over);
    chk({e.tag, ".win"},  winner,    e.win);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      y = 10'd481; x = 10'd0;
      step();
      y = 10'd0; x = 10'd5;
      step();
    end
  endtask

  task automatic serve_press();
    btn_serve = 1'b1;
    repeat (5) step();
    btn_serve = 1'b0;
    step();
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    reset_n = 1'b0; x = '0; y = '0;
    score1 = 1'b0; score2 = 1'b0; btn_serve = 1'b0;
    e_p1 = 0; e_p2 = 0; e_hold = 1; e_over = 0; e_win = 2'b00;

    repeat (3) step();
    sb_push("reset"); sb_check();
    reset_n = 1'b1;
    step();

    // IDLE ignores score edges
    score1 = 1'b1;
    sb_push("idle_rise"); step(); sb_check();
    score1 = 1'b0; step();

    // serve latency: ball_hold falls on the 4th edge after btn rises
    btn_serve = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      e_hold = (k < 4);
      sb_push($sformatf("serve_k%0d", k)); step(); sb_check();
    end
    btn_serve = 1'b0; step();

    // held flag counts once; a re-rise in PAUSE does not restart the counter
    score1 = 1'b1;
    e_p1 = 1; e_hold = 1;
    sb_push("p1_point"); step(); sb_check();
    do_ticks(30);
    score1 = 1'b0; step();
    score1 = 1'b1; step();
    do_ticks(29);
    sb_push("pause_59"); sb_check();
    do_ticks(1);
    e_hold = 0;
    sb_push("pause_60"); sb_check();
    repeat (3) step();
    sb_push("held_reentry"); sb_check();
    score1 = 1'b0; step();

    // simultaneous flags: tied point discarded
    score1 = 1'b1; score2 = 1'b1;
    e_hold = 1;
    sb_push("tie"); step(); sb_check();
    score1 = 1'b0; score2 = 1'b0;
    do_ticks(59);
    sb_push("tie_59"); sb_check();
    do_ticks(1);
    e_hold = 0;
    sb_push("tie_60"); sb_check();

    // player 2 wins the match
    for (int i = 1; i <= 7; i++) begin
      score2 = 1'b1;
      e_p2 = 4'(i); e_hold = 1;
      e_over = (i == 7); e_win = (i == 7) ? 2'b10 : 2'b00;
      sb_push($sformatf("p2_pt%0d", i)); step(); sb_check();
      score2 = 1'b0; step();
      if (i < 7) begin
        do_ticks(60);
        e_hold = 0;
        sb_push($sformatf("p2_resume%0d", i)); sb_check();
      end
    end
    score1 = 1'b1; step(); score1 = 1'b0; step();
    sb_push("over_p1_ignored"); sb_check();

    // restart from OVER
    btn_serve = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin
        e_p1 = 0; e_p2 = 0; e_over = 0; e_win = 2'b00;
      end
      sb_push($sformatf("restart_k%0d", k)); step(); sb_check();
    end
    step(); btn_serve = 1'b0;
    repeat (4) step();
    sb_push("idle_after_over"); sb_check();

    serve_press();
    e_hold = 0;
    sb_push("play2"); sb_check();

    // build p1=3, then hit async reset mid-PAUSE
    for (int i = 1; i <= 3; i++) begin
      score1 = 1'b1; step(); score1 = 1'b0; step();
      do_ticks(i < 3 ? 60 : 10);
    end
    e_p1 = 3; e_hold = 1;
    sb_push("pre_reset"); sb_check();
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    e_p1 = 0; e_p2 = 0; e_hold = 1; e_over = 0; e_win = 2'b00;
    sb_push("async_reset"); sb_check();
    repeat (2) step();
    sb_push("reset_held"); sb_check();
    reset_n = 1'b1;
    repeat (2) step();
    sb_push("post_reset_idle"); sb_check();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
